mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single byte-wide 512x8 memory port between instruction fetch (IF) and the
//   load/store data unit (D). Arbitrates requests, sequences 1/2/4 byte-cycle transfers,
//   assembles/splits big-endian words and returns a one-cycle ack per transfer.
// PARAMETERS
//   ADDR_W   9   byte address width; all address arithmetic wraps modulo 2**ADDR_W
//   FAIR_RR  1   1: round-robin on simultaneous requests; 0: D always wins ties
// PORTS
//   clk        in   1       clock, rising edge
//   clr        in   1       reset, asynchronous, active-low
//   if_req     in   1       IF request; held high until if_ack
//   if_addr    in   ADDR_W  IF word byte-address
//   if_ack     out  1       one-cycle pulse: IF transfer complete, if_rdata valid
//   if_rdata   out  32      fetched word, big-endian
//   if_err     out  1       IF misaligned (valid with if_ack)
//   d_req      in   1       data request; held high until d_ack
//   d_we       in   1       1 write, 0 read
//   d_size     in   2       00 byte, 01 half, 10 word, 11 treated as word
//   d_addr     in   ADDR_W  data byte-address
//   d_wdata    in   32      write data, right-aligned
//   d_ack      out  1       one-cycle pulse: data transfer complete
//   d_rdata    out  32      read data, right-aligned, zero-extended
//   d_err      out  1       data misaligned (valid with d_ack)
//   mem_addr   out  ADDR_W  byte address to memory
//   mem_we     out  1       byte write strobe
//   mem_wdata  out  8       byte write data
//   mem_rdata  in   8       byte read data, combinational from mem_addr
// BEHAVIOUR
//   - Reset (clr=0, async): state IDLE, all outputs 0, last_gnt=D (first tie goes to IF).
//   - FSM IDLE -> XFER -> ACK -> IDLE. Req/addr/size/wdata/we sampled only in IDLE.
//   - IDLE: on edge with a request, latch winner's base/size/wdata/we; byte count N = 1/2/4
//     (IF always 4); idx=0; go XFER. Tie: FAIR_RR=1 grants requester != last_gnt; else D.
//   - XFER: mem_addr=(base+idx) mod 2**ADDR_W; read: mem_rdata shifted into result at edge
//     (first byte most significant); write: mem_we=1, mem_wdata = byte (N-1-idx) of d_wdata
//     (MSB first). idx++ each edge; at idx==N-1 go ACK, update last_gnt.
//   - ACK: winner's ack=1 for exactly one cycle with rdata/err valid; -> IDLE unconditionally.
//     rdata holds until next ack of same port. Requester drops req at edge after ack.
//   - Latency req-sample to ack: word 5 cycles, half 3, byte 2. Max throughput one ack per N+2.
//   - Outside XFER: mem_we=0, mem_wdata=0, mem_addr holds last value (0 after reset).
//   - Unrequesting port never acked; no request in IDLE -> stays IDLE, no memory activity.
//   - Reset mid-XFER: abort immediately, no ack; bytes already written stay in memory.
//   - Address wrap: word at 0x1FF without align check reads 0x1FF,0x000,0x001,0x002.
// CONFIGURATION
//   MEM_ARB_ALIGN_CHECK_EN defined: half with addr[0]!=0 or word with addr[1:0]!=0 (IF or D)
//     skips XFER: IDLE -> ACK directly, err=1, rdata=0, no mem_we; last_gnt still updated.
//   Undefined: no check; if_err/d_err tied 0; misaligned accesses proceed byte-wise w/ wrap.
// TESTING
//   1 Reset: clr=0 mid-run -> all outputs 0 same cycle; after release IDLE, mem_we never pulses.
//   2 IF read 0x004, mem {04:8A,05:10,06:00,07:01} -> if_ack 5 cycles later, if_rdata=0x8A100001.
//   3 D write word 0xDEADBEEF @0x010 then D read half @0x012 -> mem 10..13=DE AD BE EF,
//     d_rdata=0x0000BEEF; D read byte @0x011 -> 0x000000AD, ack after 2 cycles.
//   4 if_req and d_req both held high from reset, FAIR_RR=1 -> acks alternate IF,D,IF,D;
//     FAIR_RR=0 -> D served each time while d_req high, IF only after d_req drops.
//   5 D read word @0x1FF, align check off -> bytes 1FF,000,001,002 assembled; with
//     MEM_ARB_ALIGN_CHECK_EN -> d_ack 1 cycle after sample, d_err=1, d_rdata=0, no write.
//   6 D write word @0x020, clr=0 after 2 XFER cycles -> only 0x020,0x021 modified, no d_ack.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: lets instruction fetch (IF) and the load/store unit (D)
// share one byte-wide memory port. Each transfer moves 1, 2 or 4 bytes in
// big-endian order and ends with a one-cycle ack to the port that won.
// Optional build macro: MEM_ARB_ALIGN_CHECK_EN turns misaligned half/word
// accesses into an immediate error ack that never touches memory.
module mem_port_arbiter #(
  parameter int ADDR_W  = 9,
  parameter bit FAIR_RR = 1'b1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_ACK} state_t;

  state_t            r_state;
  logic              r_gnt_d;     // current transfer belongs to D
  logic              r_last_d;    // last completed grant went to D
  logic [ADDR_W-1:0] r_base;
  logic [1:0]        r_last_idx;  // byte count minus one
  logic [1:0]        r_idx;
  logic              r_we;
  logic [31:0]       r_wdata;
  logic [23:0]       r_shift;     // bytes read so far, oldest most significant
  logic              r_if_ack;
  logic [31:0]       r_if_rdata;
  logic              r_d_ack;
  logic [31:0]       r_d_rdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we;
  logic [7:0]        r_mem_wdata;

  logic              w_any;
  logic              w_gnt_d;
  logic [ADDR_W-1:0] w_addr;
  logic [1:0]        w_last_idx;
  logic              w_we;
  logic              w_mis;
  logic [ADDR_W-1:0] w_next_addr;
  logic [31:0]       w_assembled;

  // Byte k of a right-aligned word (k=0 is the least significant byte).
  function automatic logic [7:0] f_byte(input logic [31:0] word, input logic [1:0] k);
    case (k)
      2'd0:    f_byte = word[7:0];
      2'd1:    f_byte = word[15:8];
      2'd2:    f_byte = word[23:16];
      default: f_byte = word[31:24];
    endcase
  endfunction

  // Without a tie, the lone requester wins; on a tie either alternate or favour D.
  assign w_any       = if_req | d_req;
  assign w_gnt_d     = d_req & (~if_req | (FAIR_RR ? ~r_last_d : 1'b1));
  assign w_addr      = w_gnt_d ? d_addr : if_addr;
  assign w_we        = w_gnt_d & d_we;
  assign w_next_addr = r_base + ADDR_W'(r_idx) + ADDR_W'(1);
  assign w_assembled = {r_shift, mem_rdata};

  // Transfer length of the request that would be granted this cycle.
  always_comb begin
    w_last_idx = 2'd3;
    if (w_gnt_d) begin
      case (d_size)
        2'b00:   w_last_idx = 2'd0;
        2'b01:   w_last_idx = 2'd1;
        default: w_last_idx = 2'd3;
      endcase
    end
  end

`ifdef MEM_ARB_ALIGN_CHECK_EN
  logic r_if_err;
  logic r_d_err;
  assign w_mis  = ((w_last_idx == 2'd1) && w_addr[0]) ||
                  ((w_last_idx == 2'd3) && (w_addr[1:0] != 2'b00));
  assign if_err = r_if_err;
  assign d_err  = r_d_err;
`else
  assign w_mis  = 1'b0;
  assign if_err = 1'b0;
  assign d_err  = 1'b0;
`endif

  // Arbitration and byte sequencing FSM; every output is registered here.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state     <= S_IDLE;
      r_gnt_d     <= 1'b0;
      r_last_d    <= 1'b1;
      r_base      <= '0;
      r_last_idx  <= 2'd0;
      r_idx       <= 2'd0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_shift     <= '0;
      r_if_ack    <= 1'b0;
      r_if_rdata  <= '0;
      r_d_ack     <= 1'b0;
      r_d_rdata   <= '0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
`ifdef MEM_ARB_ALIGN_CHECK_EN
      r_if_err    <= 1'b0;
      r_d_err     <= 1'b0;
`endif
    end else begin
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;
`ifdef MEM_ARB_ALIGN_CHECK_EN
      r_if_err <= 1'b0;
      r_d_err  <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt_d    <= w_gnt_d;
            r_base     <= w_addr;
            r_last_idx <= w_last_idx;
            r_we       <= w_we;
            r_wdata    <= d_wdata;
            r_idx      <= 2'd0;
            r_shift    <= '0;
            if (w_mis) begin
              // Misaligned: answer at once with an error, memory untouched.
              r_state  <= S_ACK;
              r_last_d <= w_gnt_d;
              if (w_gnt_d) begin
                r_d_ack   <= 1'b1;
                r_d_rdata <= '0;
              end else begin
                r_if_ack   <= 1'b1;
                r_if_rdata <= '0;
              end
`ifdef MEM_ARB_ALIGN_CHECK_EN
              r_d_err  <= w_gnt_d;
              r_if_err <= ~w_gnt_d;
`endif
            end else begin
              r_state     <= S_XFER;
              r_mem_addr  <= w_addr;
              r_mem_we    <= w_we;
              r_mem_wdata <= w_we ? f_byte(d_wdata, w_last_idx) : 8'h00;
            end
          end
        end
        S_XFER: begin
          r_shift <= {r_shift[15:0], mem_rdata};
          if (r_idx == r_last_idx) begin
            r_state     <= S_ACK;
            r_last_d    <= r_gnt_d;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= 8'h00;
            if (r_gnt_d) begin
              r_d_ack <= 1'b1;
              if (!r_we) r_d_rdata <= w_assembled;
            end else begin
              r_if_ack   <= 1'b1;
              r_if_rdata <= w_assembled;
            end
          end else begin
            r_idx      <= r_idx + 2'd1;
            r_mem_addr <= w_next_addr;
            if (r_we) r_mem_wdata <= f_byte(r_wdata, r_last_idx - r_idx - 2'd1);
          end
        end
        S_ACK:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign if_ack    = r_if_ack;
  assign if_rdata  = r_if_rdata;
  assign d_ack     = r_d_ack;
  assign d_rdata   = r_d_rdata;
  assign mem_addr  = r_mem_addr;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: byte memory model, directed transfers,
// scoreboard queue of expected acks checked by an independent monitor.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        clr;
  logic        if_req;
  logic [8:0]  if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic [8:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [8:0]  mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(9), .FAIR_RR(1'b1)) dut (
    .clk(clk), .clr(clr),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Byte memory with combinational read and a bench preload port.
  logic [7:0] mem [512];
  logic       pl_en = 1'b0;
  logic [8:0] pl_addr = '0;
  logic [7:0] pl_data = '0;
  int         we_cnt = 0;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      we_cnt        <= we_cnt + 1;
    end else if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    bit          is_d;
    bit          chk_data;
    logic [31:0] data;
    bit          err;
  } exp_t;

  exp_t sb[$];

  task automatic push_exp(input bit is_d, input bit chk_data, input logic [31:0] data, input bit err);
    exp_t e;
    e.is_d = is_d; e.chk_data = chk_data; e.data = data; e.err = err;
    sb.push_back(e);
  endtask

  // Monitor: every ack pops one expectation and is compared against it.
  always @(negedge clk) begin
    exp_t e;
    if (clr && (if_ack || d_ack)) begin
      chk("dual_ack", {31'b0, if_ack & d_ack}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("ack_port", {31'b0, d_ack}, {31'b0, e.is_d});
        if (e.is_d) begin
          if (e.chk_data) chk("d_rdata", d_rdata, e.data);
          chk("d_err", {31'b0, d_err}, {31'b0, e.err});
        end else begin
          chk("if_rdata", if_rdata, e.data);
          chk("if_err", {31'b0, if_err}, {31'b0, e.err});
        end
      end
    end
  end

  task automatic poke(input logic [8:0] a, input logic [7:0] v);
    @(posedge clk); #1;
    pl_addr = a; pl_data = v; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic run_if(input logic [8:0] addr, input int exp_lat, input string name);
    int cnt = 0;
    bit got = 1'b0;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = addr;
    while (!got && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
      if (if_ack) got = 1'b1;
    end
    if_req = 1'b0;
    chk(name, 32'(cnt), 32'(exp_lat));
  endtask

  task automatic run_d(input bit we, input logic [1:0] size, input logic [8:0] addr,
                       input logic [31:0] wd, input int exp_lat, input string name);
    int cnt = 0;
    bit got = 1'b0;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = we; d_size = size; d_addr = addr; d_wdata = wd;
    while (!got && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
      if (d_ack) got = 1'b1;
    end
    d_req = 1'b0;
    chk(name, 32'(cnt), 32'(exp_lat));
  endtask

  initial begin
    int we0;
    int nack;
    int cyc;
    bit rif;
    bit rd;

    clr = 1'b0; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_addr = '0; d_wdata = '0;

    // Reset state and quiet idle.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", {27'b0, if_ack, if_err, d_ack, d_err, mem_we}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_mem_port", {15'b0, mem_addr, mem_wdata}, 32'd0);
    clr = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("idle_no_we", 32'(we_cnt), 32'd0);
    chk("idle_addr", 32'(mem_addr), 32'd0);

    // IF word fetch.
    poke(9'h004, 8'h8A); poke(9'h005, 8'h10); poke(9'h006, 8'h00); poke(9'h007, 8'h01);
    push_exp(1'b0, 1'b1, 32'h8A100001, 1'b0);
    run_if(9'h004, 5, "if_word_lat");

    // D word write, then half and byte reads of it.
    push_exp(1'b1, 1'b0, 32'h0, 1'b0);
    run_d(1'b1, 2'b10, 9'h010, 32'hDEADBEEF, 5, "d_wr_lat");
    chk("mem_10_13", {mem[9'h010], mem[9'h011], mem[9'h012], mem[9'h013]}, 32'hDEADBEEF);
    push_exp(1'b1, 1'b1, 32'h0000BEEF, 1'b0);
    run_d(1'b0, 2'b01, 9'h012, 32'h0, 3, "d_half_lat");
    push_exp(1'b1, 1'b1, 32'h000000AD, 1'b0);
    run_d(1'b0, 2'b00, 9'h011, 32'h0, 2, "d_byte_lat");

    // Both requesters held from reset: round-robin IF, D, IF, D.
    @(posedge clk); #1;
    clr = 1'b0;
    if_req = 1'b1; if_addr = 9'h004;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b00; d_addr = 9'h011;
    push_exp(1'b0, 1'b1, 32'h8A100001, 1'b0);
    push_exp(1'b1, 1'b1, 32'h000000AD, 1'b0);
    push_exp(1'b0, 1'b1, 32'h8A100001, 1'b0);
    push_exp(1'b1, 1'b1, 32'h000000AD, 1'b0);
    @(posedge clk); #1;
    clr = 1'b1;
    nack = 0; cyc = 0; rif = 1'b0; rd = 1'b0;
    while (nack < 4 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (rif) begin if_req = 1'b1; rif = 1'b0; end
      if (rd)  begin d_req  = 1'b1; rd  = 1'b0; end
      if (if_ack) begin nack++; if_req = 1'b0; rif = 1'b1; end
      if (d_ack)  begin nack++; d_req  = 1'b0; rd  = 1'b1; end
    end
    if_req = 1'b0; d_req = 1'b0;
    chk("arb_ack_count", 32'(nack), 32'd4);

    // Word read across the top of the address space.
    poke(9'h1FF, 8'h11); poke(9'h000, 8'h22); poke(9'h001, 8'h33); poke(9'h002, 8'h44);
    we0 = we_cnt;
`ifdef MEM_ARB_ALIGN_CHECK_EN
    push_exp(1'b1, 1'b1, 32'h0, 1'b1);
    run_d(1'b0, 2'b10, 9'h1FF, 32'h0, 1, "d_wrap_err_lat");
    push_exp(1'b1, 1'b1, 32'h0, 1'b1);
    run_d(1'b1, 2'b01, 9'h013, 32'h0000AAAA, 1, "d_mis_wr_lat");
    chk("mis_wr_mem13", 32'(mem[9'h013]), 32'h000000EF);
`else
    push_exp(1'b1, 1'b1, 32'h11223344, 1'b0);
    run_d(1'b0, 2'b10, 9'h1FF, 32'h0, 5, "d_wrap_lat");
`endif
    chk("wrap_no_we", 32'(we_cnt - we0), 32'd0);

    // Reset in the middle of a word write.
    poke(9'h020, 8'h55); poke(9'h021, 8'h55); poke(9'h022, 8'h55); poke(9'h023, 8'h55);
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_addr = 9'h020; d_wdata = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    #1;
    clr = 1'b0; d_req = 1'b0;
    #1;
    chk("midrst_ctrl", {27'b0, if_ack, if_err, d_ack, d_err, mem_we}, 32'd0);
    chk("midrst_mem_port", {15'b0, mem_addr, mem_wdata}, 32'd0);
    chk("midrst_if_rdata", if_rdata, 32'd0);
    chk("midrst_d_rdata", d_rdata, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    clr = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_mem_20_23", {mem[9'h020], mem[9'h021], mem[9'h022], mem[9'h023]}, 32'hCAFE5555);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
